// File: rtl/inst_encoder_loader.sv
// Packs opcode/register/address fields into 32-bit instruction words and writes them to
// consecutive instruction-memory locations from 0. Optional feature macro: FIELD_CHECK_EN.
module inst_encoder_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    opcode,
    input  logic [4:0]    reg_addr_0,
    input  logic [4:0]    reg_addr_1,
    input  logic [4:0]    reg_addr_2,
    input  logic [15:0]   addr,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          field_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] ONE      = (AW + 1)'(1);

    state_t        state_q, state_d;
    logic          imem_we_q, imem_we_d;
    logic [AW-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]   imem_wdata_q, imem_wdata_d;
    logic [AW:0]   count_q, count_d;
    logic          field_err_q, field_err_d;
    logic          xfer;
    logic          field_bad;

`ifdef FIELD_CHECK_EN
    assign field_bad = |reg_addr_2[4:3];
`else
    // Upper register bits are dropped by the word format, so they are never flagged.
    logic unused_reg_hi;
    assign unused_reg_hi = ^reg_addr_2[4:3];
    assign field_bad     = 1'b0;
`endif

    assign xfer = in_valid && (state_q == S_LOAD);

    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        count_d      = count_q;
        field_err_d  = field_err_q;
        case (state_q)
            S_LOAD: begin
                if (xfer) begin
                    if (field_bad) begin
                        field_err_d = 1'b1;
                    end else begin
                        imem_we_d    = 1'b1;
                        // count doubles as the write pointer; it never exceeds DEPTH
                        imem_addr_d  = count_q[AW-1:0];
                        imem_wdata_d = {opcode, reg_addr_0, reg_addr_1, reg_addr_2[2:0], addr};
                        count_d      = count_q + ONE;
                        if (count_q == LAST_IDX) state_d = S_DONE;
                    end
                end
                if (finish) state_d = S_DONE;
            end
            default: begin
                if (start) begin
                    state_d     = S_LOAD;
                    count_d     = '0;
                    field_err_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            count_q      <= '0;
            field_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            count_q      <= count_d;
            field_err_q  <= field_err_d;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign count      = count_q;
    assign field_err  = field_err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader with a 4-word instruction memory.
module tb_inst_encoder_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst, start, finish, in_valid, in_ready;
    logic [2:0]    opcode;
    logic [4:0]    reg_addr_0, reg_addr_1, reg_addr_2;
    logic [15:0]   addr;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          busy, done, field_err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt;

    inst_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .reg_addr_0(reg_addr_0), .reg_addr_1(reg_addr_1),
        .reg_addr_2(reg_addr_2), .addr(addr),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .busy(busy), .done(done), .field_err(field_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [2:0] op, input logic [4:0] r0,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [15:0] a);
        in_valid = v; opcode = op; reg_addr_0 = r0; reg_addr_1 = r1;
        reg_addr_2 = r2; addr = a;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0;
        put(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        tick(); tick();

        // reset state
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ferr", 32'(field_err), 0);
        chk("rst_ready", 32'(in_ready), 0);
        rst = 1'b0;

        // test 1: single encoded transfer
        do_start();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready", 32'(in_ready), 1);
        put(1'b1, 3'b101, 5'd7, 5'd18, 5'd5, 16'h1234);
        tick();
        put(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        chk("t1_we", 32'(imem_we), 1);
        chk("t1_addr", 32'(imem_addr), 0);
        chk("t1_wdata", imem_wdata, 32'hA7951234);
        chk("t1_count", 32'(count), 1);
        tick();
        chk("t1_we_drop", 32'(imem_we), 0);
        chk("t1_wdata_hold", imem_wdata, 32'hA7951234);

        // test 2: fill all 4 words, 5th tuple refused
        finish = 1'b1; tick(); finish = 1'b0;
        do_start();
        chk("t2_count_clr", 32'(count), 0);
        put(1'b1, 3'b001, 5'd0, 5'd0, 5'd0, 16'h0100); tick();
        chk("t2_we0", 32'(imem_we), 1);
        chk("t2_addr0", 32'(imem_addr), 0);
        chk("t2_wdata0", imem_wdata, 32'h2000_0100);
        put(1'b1, 3'b001, 5'd1, 5'd0, 5'd0, 16'h0101); tick();
        chk("t2_addr1", 32'(imem_addr), 1);
        chk("t2_wdata1", imem_wdata, 32'h2100_0101);
        put(1'b1, 3'b001, 5'd2, 5'd0, 5'd0, 16'h0102); tick();
        chk("t2_addr2", 32'(imem_addr), 2);
        put(1'b1, 3'b001, 5'd3, 5'd0, 5'd0, 16'h0103); tick();
        chk("t2_we3", 32'(imem_we), 1);
        chk("t2_addr3", 32'(imem_addr), 3);
        chk("t2_wdata3", imem_wdata, 32'h2300_0103);
        chk("t2_count4", 32'(count), 4);
        chk("t2_done", 32'(done), 1);
        chk("t2_ready", 32'(in_ready), 0);
        put(1'b1, 3'b001, 5'd4, 5'd0, 5'd0, 16'h0104); tick();
        chk("t2_we5", 32'(imem_we), 0);
        chk("t2_wdata5", imem_wdata, 32'h2300_0103);
        chk("t2_count5", 32'(count), 4);
        chk("t2_done5", 32'(done), 1);
        chk("t2_addr5", 32'(imem_addr), 3);

        // test 3: finish together with the third transfer
        put(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        do_start();
        chk("t3_done_clr", 32'(done), 0);
        put(1'b1, 3'b010, 5'd1, 5'd1, 5'd1, 16'hAAAA); tick();
        put(1'b1, 3'b010, 5'd2, 5'd2, 5'd2, 16'hBBBB); tick();
        put(1'b1, 3'b111, 5'd31, 5'd31, 5'd7, 16'hFFFF); finish = 1'b1; tick();
        finish = 1'b0; put(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        chk("t3_we", 32'(imem_we), 1);
        chk("t3_addr", 32'(imem_addr), 2);
        chk("t3_wdata", imem_wdata, 32'hFFFF_FFFF);
        chk("t3_done", 32'(done), 1);
        chk("t3_count", 32'(count), 3);
        tick();
        chk("t3_we_drop", 32'(imem_we), 0);
        chk("t3_count_hold", 32'(count), 3);

        // test 4: reset mid-load
        do_start();
        put(1'b1, 3'b011, 5'd3, 5'd3, 5'd3, 16'h0003); tick(); tick();
        chk("t4_pre_count", 32'(count), 2);
        rst = 1'b1; tick(); rst = 1'b0;
        put(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        chk("t4_count", 32'(count), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_ready", 32'(in_ready), 0);
        chk("t4_we", 32'(imem_we), 0);
        chk("t4_wdata", imem_wdata, 0);
        do_start();
        put(1'b1, 3'b100, 5'd0, 5'd0, 5'd0, 16'h0042); tick();
        put(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        chk("t4_we2", 32'(imem_we), 1);
        chk("t4_addr2", 32'(imem_addr), 0);
        chk("t4_wdata2", imem_wdata, 32'h8000_0042);

        // test 5: reg_addr_2 out of the 3-bit range
        put(1'b1, 3'b000, 5'd0, 5'd0, 5'd9, 16'h0000); tick();
        put(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
`ifdef FIELD_CHECK_EN
        chk("t5_we", 32'(imem_we), 0);
        chk("t5_ferr", 32'(field_err), 1);
        chk("t5_count", 32'(count), 1);
        tick();
        chk("t5_ferr_sticky", 32'(field_err), 1);
        exp_cnt = 1;
`else
        chk("t5_we", 32'(imem_we), 1);
        chk("t5_addr", 32'(imem_addr), 1);
        chk("t5_wdata", imem_wdata, 32'h0001_0000);
        chk("t5_ferr", 32'(field_err), 0);
        chk("t5_count", 32'(count), 2);
        exp_cnt = 2;
`endif
        finish = 1'b1; tick(); finish = 1'b0;
        do_start();
        chk("t5_ferr_clr", 32'(field_err), 0);

        // test 6: gapped valid, start pulsed mid-load has no effect
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            logic v;
            v = (i != 1) && (i != 4);
            put(v, 3'b110, 5'(i), 5'd0, 5'd0, 16'(i));
            start = (i == 1) || (i == 2);
            tick();
            if (v) begin
                chk("t6_we", 32'(imem_we), 1);
                chk("t6_addr", 32'(imem_addr), 32'(exp_cnt));
                chk("t6_wdata", imem_wdata, {3'b110, 5'(i), 5'd0, 3'd0, 16'(i)});
                exp_cnt++;
            end else begin
                chk("t6_we_gap", 32'(imem_we), 0);
            end
            chk("t6_count", 32'(count), 32'(exp_cnt));
            chk("t6_busy", 32'(busy), 1);
        end
        start = 1'b0;
        put(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
